// File: rtl/data_buffer.sv
// data_buffer: shared byte FIFO between the USB receiver, the USB transmitter
// and the AHB-lite slave. First-word fall-through head shared by both readers;
// occupancy is derived from the pointer difference.
// DEPTH must be a power of two so the address bits wrap naturally.
module data_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     flush,
  input  logic                     store_rx_packet_data,
  input  logic [7:0]               rx_packet_data,
  input  logic                     store_tx_data,
  input  logic [7:0]               tx_data,
  input  logic                     get_rx_data,
  output logic [7:0]               rx_data,
  input  logic                     get_tx_packet_data,
  output logic [7:0]               tx_packet_data,
  output logic [$clog2(DEPTH):0]   buffer_occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] occ;
  logic          full, empty;
  logic          wr_req, rd_req, wr_en, rd_en, reset_ptrs;
  logic [7:0]    wr_data;
  logic [7:0]    head;

  // Occupancy and full/empty from the pointers registered at cycle start.
  always_comb begin
    occ   = wptr_q - rptr_q;
    full  = (occ == PW'(DEPTH));
    empty = (occ == '0);
  end

  // Request arbitration: the receiver's write wins over the AHB write, and
  // either read strobe pops the single shared head entry once.
  always_comb begin
    wr_req     = store_rx_packet_data | store_tx_data;
    wr_data    = store_rx_packet_data ? rx_packet_data : tx_data;
    rd_req     = get_rx_data | get_tx_packet_data;
    reset_ptrs = flush | clear;
    // flush/clear discards any same-cycle write or pop.
    wr_en      = wr_req & ~full & ~reset_ptrs;
    rd_en      = rd_req & ~empty & ~reset_ptrs;
  end

  // Next-state pointers.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (reset_ptrs) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PW'(1);
      if (rd_en) rptr_d = rptr_q + PW'(1);
    end
  end

  // Pointer registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are intentionally left unreset and uncleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= wr_data;
  end

  // Fall-through head, forced to zero when empty.
  always_comb begin
    head = 8'h00;
    if (!empty) head = mem[rptr_q[AW-1:0]];
  end

  // Outputs depend only on registers and the array.
  always_comb begin
    rx_data          = head;
    tx_packet_data   = head;
    buffer_occupancy = occ;
  end

endmodule
